// File: rtl/mux_rr_nxw.sv
// mux_rr_nxw: N-channel, W-bit streaming multiplexer with a registered
// output stage. The grant comes from a direct select input or from a fair
// round-robin search. The search pointer moves past each round-robin winner.
//
// Handshake rule (all ports): a beat moves on a rising edge exactly when
// valid and ready are both high in that cycle. A producer keeps valid and
// data stable until its beat is taken. in_ready never depends on in_data.
// in_ready depends combinationally on in_valid, mode, sel and out_ready.
module mux_rr_nxw #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int CW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [CW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic [CW-1:0]   out_chan,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [CW-1:0] out_chan_q, out_chan_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] ptr_q, ptr_d;

    logic          load;
    logic          gnt_valid;
    logic [CW-1:0] gnt;
    logic [W-1:0]  gnt_data;
    logic          xfer;

    // The output register can take a beat when it is empty or being drained.
    assign load = !out_valid_q || out_ready;
    assign xfer = load && gnt_valid;

    // Grant selection. In direct mode, sel picks the channel. An out-of-range
    // sel matches no channel, so it gives no grant. In round-robin mode, the
    // first pass scans ptr..N-1 and the second pass scans 0..ptr-1.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        if (!mode) begin
            for (int k = 0; k < N; k++) begin
                if (sel == CW'(k) && in_valid[k]) begin
                    gnt_valid = 1'b1;
                    gnt       = CW'(k);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!gnt_valid && CW'(k) >= ptr_q && in_valid[k]) begin
                    gnt_valid = 1'b1;
                    gnt       = CW'(k);
                end
            end
            for (int k = 0; k < N; k++) begin
                if (!gnt_valid && CW'(k) < ptr_q && in_valid[k]) begin
                    gnt_valid = 1'b1;
                    gnt       = CW'(k);
                end
            end
        end
    end

    // Steer the granted channel's data to the output register input.
    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt == CW'(k)) begin
                gnt_data = in_data[k*W +: W];
            end
        end
    end

    // One-hot ready goes to the granted channel, and only when the register can load.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = xfer && (gnt == CW'(k));
        end
    end

    // Next state: fill on transfer, otherwise drain on out_ready.
    // The pointer moves only on a round-robin transfer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = gnt_data;
            out_chan_d  = gnt;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = (gnt == CW'(N - 1)) ? '0 : gnt + CW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers. Reset clears everything immediately, without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_nxw.sv
// Testbench for mux_rr_nxw: an N=4 and an N=3 instance run side by side.
// Both are checked against a reference model written from the grant rules.
module tb_mux_rr_nxw;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic [31:0] d4;
    logic [3:0]  v4, rdy4;
    logic        m4, ov4, or4;
    logic [1:0]  s4, oc4;
    logic [7:0]  od4;

    logic [23:0] d3;
    logic [2:0]  v3, rdy3;
    logic        m3, ov3, or3;
    logic [1:0]  s3, oc3;
    logic [7:0]  od3;

    mux_rr_nxw #(.N(4), .W(8)) dut4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .in_ready(rdy4),
        .mode(m4), .sel(s4), .out_data(od4), .out_chan(oc4),
        .out_valid(ov4), .out_ready(or4)
    );

    mux_rr_nxw #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(rdy3),
        .mode(m3), .sel(s3), .out_data(od3), .out_chan(oc3),
        .out_valid(ov3), .out_ready(or3)
    );

    // ---------------- scoreboard / reference model ----------------
    int total;
    int bad;

    logic       mv4, mv3;
    logic [7:0] mdat4, mdat3;
    int         mch4, mch3, mp4, mp3;
    logic [3:0] acc4, smp_rdy4;
    logic [2:0] acc3, smp_rdy3;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Grant rule: direct mode uses sel if it is in range and valid. Round-robin
    // mode uses the first valid channel in the order p, p+1, ... taken mod n.
    function automatic int ref_grant(input int n, input logic [15:0] v, input logic md,
                                     input int sl, input int p);
        int c;
        if (!md) return (sl < n && v[sl]) ? sl : -1;
        for (int i = 0; i < n; i++) begin
            c = (p + i) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [15:0] ref_ready(input int n, input logic [15:0] v, input logic md,
                                              input int sl, input logic ordy, input logic mvalid,
                                              input int p);
        int g;
        g = ref_grant(n, v, md, sl, p);
        if ((!mvalid || ordy) && g >= 0) return 16'(1) << g;
        return 16'(0);
    endfunction

    task automatic ref_edge(input int n, input logic [15:0] v, input logic [127:0] d,
                            input logic md, input int sl, input logic ordy,
                            inout logic mvalid, inout logic [7:0] mdata,
                            inout int mchan, inout int mptr);
        int g;
        g = ref_grant(n, v, md, sl, mptr);
        if ((!mvalid || ordy) && g >= 0) begin
            mvalid = 1'b1;
            mdata  = d[g*8 +: 8];
            mchan  = g;
            if (md) mptr = (g + 1) % n;
        end else if (ordy) begin
            mvalid = 1'b0;
        end
    endtask

    task automatic model_reset();
        mv4 = 1'b0; mdat4 = 8'h00; mch4 = 0; mp4 = 0;
        mv3 = 1'b0; mdat3 = 8'h00; mch3 = 0; mp3 = 0;
    endtask

    // ---------------- driver tasks ----------------
    // Callers set inputs at posedge+1. One call covers one clock cycle.
    // It checks in_ready before the edge and the outputs just after it.
    task automatic step();
        logic [15:0] e4, e3;
        #2;
        e4 = ref_ready(4, 16'(v4), m4, int'(s4), or4, mv4, mp4);
        e3 = ref_ready(3, 16'(v3), m3, int'(s3), or3, mv3, mp3);
        smp_rdy4 = rdy4;
        smp_rdy3 = rdy3;
        chk("in_ready_n4", 64'(rdy4), 64'(e4));
        chk("in_ready_n3", 64'(rdy3), 64'(e3));
        acc4 = e4[3:0];
        acc3 = e3[2:0];
        @(posedge clk);
        ref_edge(4, 16'(v4), 128'(d4), m4, int'(s4), or4, mv4, mdat4, mch4, mp4);
        ref_edge(3, 16'(v3), 128'(d3), m3, int'(s3), or3, mv3, mdat3, mch3, mp3);
        #1;
        chk("out_valid_n4", 64'(ov4), 64'(mv4));
        chk("out_data_n4",  64'(od4), 64'(mdat4));
        chk("out_chan_n4",  64'(oc4), 64'(mch4));
        chk("out_valid_n3", 64'(ov3), 64'(mv3));
        chk("out_data_n3",  64'(od3), 64'(mdat3));
        chk("out_chan_n3",  64'(oc3), 64'(mch3));
    endtask

    // Pulse reset between clock edges. Outputs must clear with no edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid_n4", 64'(ov4), 64'(0));
        chk("rst_out_data_n4",  64'(od4), 64'(0));
        chk("rst_out_chan_n4",  64'(oc4), 64'(0));
        chk("rst_out_valid_n3", 64'(ov3), 64'(0));
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_before;
        logic [3:0] v;
        logic       md;
        logic [1:0] sl;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_valid;
        logic [1:0] e_chan;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl[10];

    // ---------------- test sequence ----------------
    initial begin
        total = 0;
        bad   = 0;

        // Entries 0-5: full-load fairness. Entries 6-9: sparse valids 1010,
        // both starting from pointer 0.
        for (int i = 0; i < 6; i++) begin
            tbl[i].rst_before = (i == 0);
            tbl[i].v = 4'b1111; tbl[i].md = 1'b1; tbl[i].sl = 2'd0; tbl[i].ordy = 1'b1;
            tbl[i].e_rdy   = 4'(1 << (i % 4));
            tbl[i].e_valid = 1'b1;
            tbl[i].e_chan  = 2'(i % 4);
            tbl[i].e_data  = 8'hA0 + 8'(i % 4);
        end
        for (int i = 6; i < 10; i++) begin
            tbl[i].rst_before = (i == 6);
            tbl[i].v = 4'b1010; tbl[i].md = 1'b1; tbl[i].sl = 2'd0; tbl[i].ordy = 1'b1;
            tbl[i].e_rdy   = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            tbl[i].e_valid = 1'b1;
            tbl[i].e_chan  = (i % 2 == 0) ? 2'd1 : 2'd3;
            tbl[i].e_data  = (i % 2 == 0) ? 8'hA1 : 8'hA3;
        end

        rst = 1'b1;
        d4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        v4 = 4'b0; m4 = 1'b0; s4 = 2'd0; or4 = 1'b0;
        d3 = {8'hC2, 8'hC1, 8'hC0};
        v3 = 3'b0; m3 = 1'b0; s3 = 2'd0; or3 = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst_before) do_reset();
            v4 = tbl[i].v; m4 = tbl[i].md; s4 = tbl[i].sl; or4 = tbl[i].ordy;
            step();
            chk("tbl_in_ready",  64'(smp_rdy4), 64'(tbl[i].e_rdy));
            chk("tbl_out_valid", 64'(ov4),      64'(tbl[i].e_valid));
            chk("tbl_out_chan",  64'(oc4),      64'(tbl[i].e_chan));
            chk("tbl_out_data",  64'(od4),      64'(tbl[i].e_data));
        end

        // Backpressure: load one beat, stall 3 cycles, then drain and fill together.
        do_reset();
        v4 = 4'b1111; m4 = 1'b1; or4 = 1'b1;
        step();
        or4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_in_ready", 64'(smp_rdy4), 64'(0));
            chk("stall_out_data", 64'(od4), 64'(8'hA0));
            chk("stall_out_chan", 64'(oc4), 64'(0));
            chk("stall_valid",    64'(ov4), 64'(1));
        end
        or4 = 1'b1;
        step();
        chk("refill_in_ready", 64'(smp_rdy4), 64'(4'b0010));
        chk("refill_chan",     64'(oc4), 64'(1));
        chk("refill_valid",    64'(ov4), 64'(1));

        // Direct mode: sel=2, valids 0101.
        m4 = 1'b0; s4 = 2'd2; v4 = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("direct_chan",   64'(oc4), 64'(2));
            chk("direct_ready0", 64'(smp_rdy4[0]), 64'(0));
        end
        s4 = 2'd1;
        step();
        chk("direct_nogrant_ready", 64'(smp_rdy4), 64'(0));
        chk("direct_drain_valid",   64'(ov4), 64'(0));

        // Mid-operation reset: with traffic running, the pointer is non-zero.
        m4 = 1'b1; v4 = 4'b1111; or4 = 1'b1;
        step();
        step();
        or4 = 1'b0;
        step();
        chk("pre_reset_valid", 64'(ov4), 64'(1));
        do_reset();
        or4 = 1'b1;
        step();
        chk("post_reset_ready", 64'(smp_rdy4), 64'(4'b0001));
        chk("post_reset_chan",  64'(oc4), 64'(0));

        // N=3: an out-of-range select gives no grant. Round robin then wraps 2->0.
        do_reset();
        v4 = 4'b0;
        v3 = 3'b111; m3 = 1'b0; s3 = 2'd3; or3 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("n3_oor_ready", 64'(smp_rdy3), 64'(0));
            chk("n3_oor_valid", 64'(ov3), 64'(0));
        end
        m3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("n3_rr_chan", 64'(oc3), 64'(i % 3));
            chk("n3_rr_data", 64'(od3), 64'(8'hC0 + 8'(i % 3)));
        end

        // Randomized traffic on both instances. Producers hold valid and data
        // until their beat is accepted.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (acc4[k] || !v4[k]) begin
                    v4[k] = 1'($urandom_range(0, 1));
                    d4[k*8 +: 8] = 8'($urandom_range(0, 255));
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (acc3[k] || !v3[k]) begin
                    v3[k] = 1'($urandom_range(0, 1));
                    d3[k*8 +: 8] = 8'($urandom_range(0, 255));
                end
            end
            if ($urandom_range(0, 7) == 0) m4 = ~m4;
            if ($urandom_range(0, 7) == 0) m3 = ~m3;
            if ($urandom_range(0, 3) == 0) s4 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) s3 = 2'($urandom_range(0, 3));
            or4 = ($urandom_range(0, 3) != 0);
            or3 = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
